// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write port of the
// instruction memory loader, bundled so the producer and the memory-side
// consumer see one object.
// The slave modport is the loader's view and the master modport is the
// byte source / memory view.
interface imem_loader_if #(
  parameter int ADDR_W = 14
) ();

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport slave (
    input  byte_valid,
    input  byte_data,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport master (
    output byte_valid,
    output byte_data,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

endinterface

// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
// It receives a length-prefixed byte stream:
//   - a 16-bit little-endian word count,
//   - followed by the data bytes.
// Every four bytes are packed into a little-endian 32-bit word. Each word is
// written to consecutive word addresses, starting at 0.
// The CPU is held in reset while a load is in progress, and after a failed
// load.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN. When it is defined, a
// trailing byte must equal the XOR of all header and data bytes. If it does
// not, the load ends in ERR.
module imem_loader #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  imem_loader_if.slave  bus,
  output logic          o_cpu_hold,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [15:0]   o_words_loaded
);

  // Widened by one bit so that the header length compares cleanly.
  localparam logic [16:0] LP_DEPTH = 17'(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_DONE, S_ERR
  } state_t;
`endif

  state_t            r_state;
  logic [15:0]       r_len;
  logic [1:0]        r_lane;
  logic [23:0]       r_word;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_hold;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [15:0]       r_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
  logic [7:0]        w_csum;
  logic              w_csumNow;
`endif

  state_t            w_state;
  logic [15:0]       w_len;
  logic [15:0]       w_lenFull;
  logic [1:0]        w_lane;
  logic [23:0]       w_word;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic              w_hold;
  logic              w_busy;
  logic              w_done;
  logic              w_err;
  logic [15:0]       w_count;
  logic              w_lastWrite;
  logic              w_tail;
  logic              w_good;
  logic              w_bad;

  // Next-state and next-output logic.
  // A write pulse in DATA means the word is committed this cycle:
  //   - the address and the count advance at the following edge;
  //   - if this was the last word, the load moves on to its tail (CSUM or
  //     DONE).
  // A byte arriving alongside the write pulse lands in lane 0, because the
  // lane counter already wrapped when the word was completed.
  always_comb begin
    w_state     = r_state;
    w_len       = r_len;
    w_lane      = r_lane;
    w_word      = r_word;
    w_we        = 1'b0;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_hold      = r_hold;
    w_busy      = r_busy;
    w_done      = r_done;
    w_err       = r_err;
    w_count     = r_count;
    w_lenFull   = {bus.byte_data, r_len[7:0]};
    w_lastWrite = r_we && ((r_count + 16'd1) == r_len);
    w_tail      = 1'b0;
    w_good      = 1'b0;
    w_bad       = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    w_csum      = r_csum;
    w_csumNow   = 1'b0;
`endif

    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (i_start) begin
          w_state = S_HDR0;
          w_hold  = 1'b1;
          w_busy  = 1'b1;
          w_done  = 1'b0;
          w_err   = 1'b0;
          w_count = 16'd0;
          w_addr  = '0;
          w_lane  = 2'd0;
          w_len   = 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_csum  = 8'd0;
`endif
        end
      end

      S_HDR0: begin
        if (bus.byte_valid) begin
          w_len[7:0] = bus.byte_data;
          w_state    = S_HDR1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_csum     = r_csum ^ bus.byte_data;
`endif
        end
      end

      S_HDR1: begin
        if (bus.byte_valid) begin
          w_len  = w_lenFull;
          w_lane = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_csum = r_csum ^ bus.byte_data;
`endif
          if ({1'b0, w_lenFull} > LP_DEPTH) begin
            w_state = S_ERR;
            w_busy  = 1'b0;
            w_err   = 1'b1;
          end else if (w_lenFull == 16'd0) begin
            w_tail = 1'b1;
          end else begin
            w_state = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (r_we) begin
          w_count = r_count + 16'd1;
          if (r_addr != '1) begin
            w_addr = r_addr + ADDR_W'(1);
          end
        end
        if (w_lastWrite) begin
          w_tail = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_csumNow = bus.byte_valid;
`endif
        end else if (bus.byte_valid) begin
          w_lane = r_lane + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_csum = r_csum ^ bus.byte_data;
`endif
          case (r_lane)
            2'd0:    w_word[7:0]   = bus.byte_data;
            2'd1:    w_word[15:8]  = bus.byte_data;
            2'd2:    w_word[23:16] = bus.byte_data;
            default: begin
              w_wdata = {bus.byte_data, r_word};
              w_we    = 1'b1;
            end
          endcase
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        w_csumNow = bus.byte_valid;
      end
`endif

      default: begin
        w_state = S_IDLE;
      end
    endcase

`ifdef IMEM_LOADER_CHECKSUM_EN
    if (w_tail) begin
      w_state = S_CSUM;
    end
    if (w_csumNow) begin
      if (bus.byte_data == r_csum) begin
        w_good = 1'b1;
      end else begin
        w_bad = 1'b1;
      end
    end
`else
    w_good = w_tail;
`endif

    if (w_good) begin
      w_state = S_DONE;
      w_done  = 1'b1;
      w_hold  = 1'b0;
      w_busy  = 1'b0;
    end
    if (w_bad) begin
      w_state = S_ERR;
      w_err   = 1'b1;
      w_busy  = 1'b0;
    end
  end

  // State and registered outputs; reset clears everything and wins over all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_len   <= 16'd0;
      r_lane  <= 2'd0;
      r_word  <= 24'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_hold  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_count <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum  <= 8'd0;
`endif
    end else begin
      r_state <= w_state;
      r_len   <= w_len;
      r_lane  <= w_lane;
      r_word  <= w_word;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_hold  <= w_hold;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_err   <= w_err;
      r_count <= w_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum  <= w_csum;
`endif
    end
  end

  assign bus.imem_we     = r_we;
  assign bus.imem_addr   = r_addr;
  assign bus.imem_wdata  = r_wdata;
  assign o_cpu_hold      = r_hold;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_err           = r_err;
  assign o_words_loaded  = r_count;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction memory. It receives a byte stream (for example from a UART receiver), packs the bytes into 32-bit little-endian instruction words, and writes them sequentially into the instruction memory write port, starting at word address 0. While a load is in progress it holds the CPU fetch unit in reset via cpu_hold. Word addresses match the fetch unit's PC[15:2] indexing.

Parameters:
ADDR_W, 14, instruction memory word-address width (PC[15:2])
DEPTH, 16384, maximum loadable words; must be <= 2**ADDR_W

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that requests a new load
byte_valid  in  1  byte_data is valid this cycle; one-cycle strobe per byte
byte_data  in  8  incoming byte
imem_we  out  1  instruction memory write enable, one-cycle pulse
imem_addr  out  ADDR_W  word address for imem_we
imem_wdata  out  32  instruction word for imem_we
cpu_hold  out  1  high while loading or after an error; OR this into the CPU reset
busy  out  1  state is not IDLE, DONE or ERR
done  out  1  load completed successfully; sticky until next start or reset
err  out  1  load aborted; sticky until next start or reset
words_loaded  out  16  count of words written in the current or last load

Behaviour:
- Reset (synchronous, clk rising edge, reset=1):
  - state=IDLE.
  - All outputs are 0: imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err, words_loaded.
  - Byte-lane counter and length register are cleared.
  - Reset wins over every other input in the same cycle. Reset during a load abandons it; words already written stay in memory.
- States: IDLE, HDR0, HDR1, DATA, CSUM (only with the optional feature), DONE, ERR.
- IDLE / DONE / ERR, start=1:
  - Next state HDR0.
  - cpu_hold=1, busy=1; done, err, words_loaded and imem_addr cleared.
- start is ignored in HDR0, HDR1, DATA and CSUM.
- byte_valid is ignored in IDLE, DONE and ERR.
- HDR0: on byte_valid, len[7:0]=byte_data, then go to HDR1.
- HDR1: on byte_valid, len[15:8]=byte_data. Then:
  - len > DEPTH -> ERR.
  - len = 0 -> DONE (or CSUM if enabled).
  - otherwise -> DATA.
- DATA packing:
  - A 2-bit lane counter places bytes little-endian: 1st byte -> bits[7:0], 4th byte -> bits[31:24].
  - On the 4th byte, imem_wdata gets the full word, and imem_we=1 in the following cycle for exactly one cycle, with imem_addr = index of that word.
  - On the cycle after imem_we, imem_addr and words_loaded increment by 1.
  - imem_we never asserts in any other state.
- DATA exit: after the write of word len-1, go to DONE (or CSUM if enabled). imem_addr then holds len; it does not wrap.
- Back-to-back byte_valid on consecutive cycles must be accepted with no byte lost. A byte arriving in the same cycle as imem_we is accepted into lane 0.
- DONE: done=1, cpu_hold=0, busy=0.
- ERR: err=1, cpu_hold=1, busy=0. The CPU stays held until a successful load or reset.
- Outputs are registered. done and err are never high at the same time.

Optional Feature:
IMEM_LOADER_CHECKSUM_EN
- Defined:
  - After the last data word (or after HDR1 when len=0), the state is CSUM.
  - The next byte is compared against the running XOR of all header and data bytes.
  - Match -> DONE. Mismatch -> ERR.
  - Words already written are not rolled back.
- Undefined:
  - The CSUM state and XOR accumulator do not exist.
  - DATA or HDR1 goes directly to DONE.

Test Plan:
- reset, start, bytes 02 00 13 05 10 00 93 05 20 00 ->
  - imem_we pulse at addr 0 with data 0x00100513; pulse at addr 1 with data 0x00200593.
  - Then done=1, cpu_hold=0, words_loaded=2.
- start, bytes 00 00 -> DONE in the cycle after the 2nd byte; imem_we never asserts; words_loaded=0.
- start, bytes 01 40 (len=16385 > DEPTH) -> err=1, cpu_hold=1, no writes. A second start followed by a valid 1-word load -> done=1, err=0.
- Load header 03 00 plus 12 data bytes with byte_valid every cycle -> 3 writes at addr 0,1,2 with no dropped bytes. A start pulse mid-stream has no effect.
- Assert reset after 6 of 8 data bytes -> next cycle all outputs 0, state IDLE. The word at addr 0 was written; addr 1 was never written.
- With IMEM_LOADER_CHECKSUM_EN, bytes 01 00 13 05 10 00:
  - Checksum byte 07 (XOR of all six bytes) -> done=1.
  - Checksum byte 00 instead -> err=1, cpu_hold=1.
